imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first): CLK input 1 (single clock, all state on rising edge); RESETn input 1 (synchronous, active-low reset).
REQ-002 SHALL have ports load_start input 1 (pulse: begin program load) and load_len input 8 (words to load, legal 1..128).
REQ-003 SHALL have ports run_start input 1 (pulse: release core without loading) and PC input 32 (core fetch address).
REQ-004 SHALL have ports rx_valid input 1, rx_data input 8 and rx_ready output 1 (byte stream from host).
REQ-005 SHALL have ports mem_rdata input 32 (128x32 instruction memory read data), mem_addr output 7, mem_we output 1 and mem_wdata output 32.
REQ-006 SHALL have ports Instr output 32 (to fetch stage), cpu_hold output 1 (holds core in stall/reset), load_done output 1 (1-cycle pulse) and load_err output 1 (sticky).

Function
REQ-007 SHALL implement states IDLE, LOAD, RUN; cpu_hold=1 in IDLE and LOAD, 0 in RUN.
REQ-008 IDLE: load_start with load_len in 1..128 -> LOAD, latch len, clear word/byte counters, clear load_err; any other load_len -> set load_err, stay IDLE.
REQ-009 IDLE: run_start (without load_start) -> RUN; load_start has priority if both asserted.
REQ-010 RUN: valid load_start -> LOAD on next edge, cpu_hold=1 from that edge; invalid load_len -> set load_err, stay RUN; run_start ignored.
REQ-011 LOAD: rx_ready=1 every cycle; byte accepted when rx_valid & rx_ready; rx_ready=0 in IDLE and RUN.
REQ-012 Bytes assembled little-endian: k-th accepted byte of a word (k=0..3) -> bits [8k+7:8k].
REQ-013 Cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_addr=word counter, mem_wdata=assembled word; word counter then increments.
REQ-014 Byte acceptance SHALL continue during the mem_we cycle without loss; back-to-back bytes every cycle supported.
REQ-015 In the mem_we cycle of word len-1: load_done=1 and state -> RUN on next edge; further rx bytes not accepted after that edge.
REQ-016 load_start, run_start during LOAD SHALL be ignored.
REQ-017 mem_we=0 whenever no word write is scheduled; memory words beyond len-1 left unmodified.
REQ-018 When mem_we=0: mem_addr = PC[8:2] (combinational).
REQ-019 Instr = mem_rdata when state RUN and PC <= 32'h000001FC; else 32'h00000000.
REQ-020 Word counter 7 bits plus terminal compare against len-1; len=128 SHALL write addresses 0..127 with no wrap before done.
REQ-021 PC[1:0] ignored; no alignment error raised.

Reset
REQ-022 RESETn=0 at a clock edge SHALL force: state IDLE, cpu_hold=1, rx_ready=0, mem_we=0, mem_wdata=0, load_done=0, load_err=0, byte/word counters 0, latched len 0.
REQ-023 Reset mid-LOAD SHALL discard partial word and cancel any pending mem_we; no write issued after reset edge.
REQ-024 Reset has priority over all other inputs in the same cycle.

Verification
REQ-025 Load 2 words: load_start, len=2, bytes 00 00 00 E2, 01 10 80 E2 back-to-back -> mem_we writes addr0=E2000000, addr1=E2801001; load_done pulse on second write; cpu_hold 0 next cycle.
REQ-026 In RUN, PC=0x4, mem_rdata=E2801001 -> Instr=E2801001, mem_addr=1; PC=0x200 -> Instr=0.
REQ-027 load_start with len=0, then len=129 -> load_err=1, state unchanged, no mem_we; subsequent valid load_start clears load_err.
REQ-028 rx_valid gaps (byte every 3rd cycle), len=128 -> exactly 128 writes addr 0..127 in order, single load_done.
REQ-029 RESETn=0 after 6 bytes of a 3-word load -> one write (addr0) only, outputs at REQ-022 values, cpu_hold=1.
REQ-030 run_start and load_start same cycle in IDLE -> enters LOAD; load_start during RUN -> cpu_hold=1 next edge, Instr=0.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a 128x32 instruction memory from a host byte stream, then releases the core to fetch.
// Ports:
//   CLK, RESETn          - clock, synchronous active-low reset
//   load_start, load_len - start a program load of load_len words (1..128)
//   run_start            - release the core without loading
//   PC, Instr            - core fetch address in, fetched instruction out
//   rx_valid/rx_data/rx_ready - host byte stream, little-endian words
//   mem_addr/mem_we/mem_wdata/mem_rdata - instruction memory port
//   cpu_hold, load_done, load_err - core hold, load-complete pulse, sticky bad-length flag
module imem_load_ctrl (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        load_start,
    input  logic [7:0]  load_len,
    input  logic        run_start,
    input  logic [31:0] PC,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic [31:0] mem_rdata,
    output logic [6:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] Instr,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t      state, state_nxt;
    logic [7:0]  len;
    logic [6:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] wbuf;
    logic        len_ok;
    logic        rx_fire;
    assign len_ok  = load_len != 8'd0 && load_len <= 8'd128;
    assign rx_fire = rx_valid && rx_ready;
    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = load_start ? (len_ok ? LOAD : IDLE) : (run_start ? RUN : IDLE);
            LOAD:    state_nxt = load_done ? RUN : LOAD;
            RUN:     state_nxt = (load_start && len_ok) ? LOAD : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        cpu_hold  = state != RUN;
        rx_ready  = state == LOAD;
        // the write cycle of the last word is the done cycle; len is 1..128 while loading
        load_done = state == LOAD && mem_we && {1'b0, word_cnt} == len - 8'd1;
        mem_addr  = mem_we ? word_cnt : PC[8:2];
        Instr     = (state == RUN && PC <= 32'h0000_01FC) ? mem_rdata : 32'h0;
    end
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            len       <= 8'd0;
            word_cnt  <= 7'd0;
            byte_cnt  <= 2'd0;
            wbuf      <= 24'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state != LOAD && load_start) begin
                if (len_ok) begin
                    len      <= load_len;
                    word_cnt <= 7'd0;
                    byte_cnt <= 2'd0;
                    load_err <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end
            if (state == LOAD) begin
                // address is consumed in the write cycle, so advance afterwards
                if (mem_we) word_cnt <= word_cnt + 7'd1;
                if (rx_fire) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd0) wbuf[7:0]   <= rx_data;
                    if (byte_cnt == 2'd1) wbuf[15:8]  <= rx_data;
                    if (byte_cnt == 2'd2) wbuf[23:16] <= rx_data;
                    if (byte_cnt == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {rx_data, wbuf};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: randomized and directed checks of imem_load_ctrl against a behavioural model.
module tb_imem_load_ctrl;
    logic        CLK = 1'b0, RESETn = 1'b0, load_start = 1'b0, run_start = 1'b0, rx_valid = 1'b0;
    logic [7:0]  load_len = 8'd0, rx_data = 8'd0;
    logic [31:0] PC = 32'd0;
    logic [31:0] mem_rdata, mem_wdata, Instr;
    logic [6:0]  mem_addr;
    logic        rx_ready, mem_we, cpu_hold, load_done, load_err;

    imem_load_ctrl dut (
        .CLK(CLK), .RESETn(RESETn), .load_start(load_start), .load_len(load_len),
        .run_start(run_start), .PC(PC), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .Instr(Instr), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {logic [6:0] a; logic [31:0] d;} wr_t;
    logic [31:0] ram [128];
    logic [31:0] mref [128];
    wr_t         wlog [$];
    int          done_cnt = 0;
    int          passed = 0, total = 0;
    bit          armed = 0;

    assign mem_rdata = ram[mem_addr];

    // model: mode 0=idle 1=load 2=run; a word is scheduled once 4 bytes are collected
    int          m_mode = 0, m_len = 0, m_words = 0;
    logic [7:0]  m_bytes [$];
    bit          m_wp = 0, m_err = 0, m_done_now;
    logic [6:0]  m_wa = 7'd0;
    logic [31:0] m_wd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge CLK) begin
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        if (load_done) done_cnt++;
        if (m_wp) mref[m_wa] = m_wd;
        if (!RESETn) begin
            m_mode = 0; m_len = 0; m_words = 0; m_bytes.delete(); m_wp = 0; m_err = 0;
        end else begin
            m_done_now = m_wp && int'(m_wa) == m_len - 1;
            m_wp = 0;
            if (m_mode == 1) begin
                if (rx_valid) begin
                    m_bytes.push_back(rx_data);
                    if (m_bytes.size() == 4) begin
                        m_wp = 1;
                        m_wa = m_words[6:0];
                        m_wd = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_words++;
                        m_bytes.delete();
                    end
                end
                if (m_done_now) m_mode = 2;
            end else if (load_start) begin
                if (load_len >= 1 && load_len <= 128) begin
                    m_mode = 1; m_len = int'(load_len); m_words = 0; m_bytes.delete(); m_err = 0;
                end else m_err = 1;
            end else if (run_start && m_mode == 0) m_mode = 2;
        end
    end

    always @(negedge CLK) if (armed) begin
        chk("cpu_hold", 32'(cpu_hold), 32'(m_mode != 2));
        chk("rx_ready", 32'(rx_ready), 32'(m_mode == 1));
        chk("mem_we", 32'(mem_we), 32'(m_wp));
        chk("mem_addr", 32'(mem_addr), 32'(m_wp ? m_wa : PC[8:2]));
        if (m_wp) chk("mem_wdata", mem_wdata, m_wd);
        chk("load_done", 32'(load_done), 32'(m_wp && int'(m_wa) == m_len - 1));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("Instr", Instr, (m_mode == 2 && PC <= 32'h1FC) ? mref[PC[8:2]] : 32'h0);
    end

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset;
        RESETn = 1'b0; load_start = 1'b0; run_start = 1'b0; rx_valid = 1'b0;
        tick; tick;
        RESETn = 1'b1;
    endtask

    task automatic start(input logic [7:0] n);
        load_start = 1'b1; load_len = n;
        tick;
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic feed(input bit gap, input bit noise);
        int cyc = 0;
        while (m_mode == 1 && cyc < 3000) begin
            rx_valid = gap ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
            rx_data  = 8'($urandom);
            if (noise) begin
                load_start = $urandom_range(0, 7) == 0;
                run_start  = $urandom_range(0, 7) == 0;
                load_len   = 8'($urandom);
            end
            PC = 32'($urandom_range(0, 1023));
            tick;
            cyc++;
        end
        rx_valid = 1'b0; load_start = 1'b0; run_start = 1'b0;
        tick;
        chk("load_finished", 32'(cpu_hold), 32'd0);
    endtask

    task automatic check_reset_values;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 128; i++) begin
            ram[i] = $urandom;
            mref[i] = ram[i];
        end
        do_reset;
        armed = 1;
        check_reset_values;

        wlog.delete(); done_cnt = 0;
        start(8'd2);
        send(8'h00); send(8'h00); send(8'h00); send(8'hE2);
        send(8'h01); send(8'h10); send(8'h80); send(8'hE2);
        tick; tick;
        chk("two_word_count", 32'(wlog.size()), 32'd2);
        chk("word0_addr", 32'(wlog[0].a), 32'd0);
        chk("word0_data", wlog[0].d, 32'hE200_0000);
        chk("word1_addr", 32'(wlog[1].a), 32'd1);
        chk("word1_data", wlog[1].d, 32'hE280_1001);
        chk("two_word_done", 32'(done_cnt), 32'd1);
        chk("run_after_load", 32'(cpu_hold), 32'd0);

        PC = 32'h4; tick;
        chk("fetch_instr", Instr, 32'hE280_1001);
        chk("fetch_addr", 32'(mem_addr), 32'd1);
        PC = 32'h200; tick;
        chk("fetch_oob", Instr, 32'h0);

        start(8'd0);
        chk("len0_err", 32'(load_err), 32'd1);
        chk("len0_stay_run", 32'(cpu_hold), 32'd0);
        start(8'd129);
        chk("len129_err", 32'(load_err), 32'd1);
        chk("len129_stay_run", 32'(cpu_hold), 32'd0);
        chk("bad_len_no_write", 32'(wlog.size()), 32'd2);
        start(8'd1);
        chk("err_cleared", 32'(load_err), 32'd0);
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        feed(1'b0, 1'b1);

        repeat (6) begin
            start($urandom_range(0, 2) == 0 ? 8'd1 : 8'($urandom_range(1, 128)));
            feed(1'b0, 1'b1);
            repeat (20) begin
                PC = 32'($urandom_range(0, 1023));
                run_start = $urandom_range(0, 1) == 1;
                tick;
            end
            run_start = 1'b0;
        end

        wlog.delete(); done_cnt = 0;
        start(8'd128);
        feed(1'b1, 1'b0);
        tick;
        chk("full_count", 32'(wlog.size()), 32'd128);
        bad = 0;
        foreach (wlog[i]) if (int'(wlog[i].a) != i) bad++;
        chk("full_order", 32'(bad), 32'd0);
        chk("full_done", 32'(done_cnt), 32'd1);

        wlog.delete();
        start(8'd3);
        for (int i = 0; i < 6; i++) send(8'($urandom));
        RESETn = 1'b0; tick;
        check_reset_values;
        RESETn = 1'b1; tick; tick;
        chk("abort_writes", 32'(wlog.size()), 32'd1);
        chk("abort_addr", 32'(wlog[0].a), 32'd0);
        chk("abort_hold", 32'(cpu_hold), 32'd1);

        start(8'd0);
        chk("idle_err", 32'(load_err), 32'd1);
        chk("idle_stay", 32'(rx_ready), 32'd0);

        load_start = 1'b1; run_start = 1'b1; load_len = 8'd1; tick;
        load_start = 1'b0; run_start = 1'b0;
        chk("prio_load", 32'(rx_ready), 32'd1);
        feed(1'b0, 1'b0);
        PC = 32'h8; tick;
        start(8'd2);
        chk("run_reload_hold", 32'(cpu_hold), 32'd1);
        chk("run_reload_instr", Instr, 32'h0);
        feed(1'b0, 1'b0);
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
